// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks FETCH/DECODE/EXEC/MEM/WB and drives datapath
// enables, selects and the shared memory handshake; unsupported opcodes park in TRAP.
module multicycle_ctrl #(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic [2:0]  imm_sel,
   output logic        alu_src_b,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        retire,
   output logic        trap
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   localparam logic [2:0] IMM_I    = 3'd0;
   localparam logic [2:0] IMM_S    = 3'd1;
   localparam logic [2:0] IMM_B    = 3'd2;
   localparam logic [2:0] IMM_J    = 3'd3;
   localparam logic [2:0] IMM_NONE = 3'd7;

   state_e     state_q, state_d;
   logic [6:0] opc;
   logic       legal;
   logic [2:0] imm_dec;
   logic       src_b_dec;

   assign opc = inst[6:0];

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         OP_IMM, OP_LD, OP_JALR: imm_of = IMM_I;
         OP_ST:                  imm_of = IMM_S;
         OP_BR:                  imm_of = IMM_B;
         OP_JAL:                 imm_of = IMM_J;
         default:                imm_of = IMM_NONE;
      endcase
   endfunction

   always_comb begin
      legal = (opc == OP_R)  || (opc == OP_IMM) || (opc == OP_LD) || (opc == OP_ST) ||
              (opc == OP_BR) || (opc == OP_JAL) || (opc == OP_JALR);
      imm_dec   = imm_of(opc);
      src_b_dec = legal && (opc != OP_R) && (opc != OP_BR);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= state_e'(RESET_STATE);
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      imm_sel   = IMM_NONE;
      alu_src_b = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 2'd0;
      retire    = 1'b0;
      trap      = 1'b0;

      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            imm_sel   = imm_dec;
            alu_src_b = src_b_dec;
            state_d   = legal ? EXEC : TRAP;
         end
         EXEC: begin
            imm_sel   = imm_dec;
            alu_src_b = src_b_dec;
            case (opc)
               OP_R, OP_IMM: state_d = WB;
               OP_LD, OP_ST: state_d = MEM;
               OP_BR: begin
                  pc_we   = br_taken;
                  pc_sel  = 2'd1;
                  retire  = 1'b1;
                  state_d = FETCH;
               end
               OP_JAL: begin
                  pc_we   = 1'b1;
                  pc_sel  = 2'd1;
                  state_d = WB;
               end
               OP_JALR: begin
                  pc_we   = 1'b1;
                  pc_sel  = 2'd2;
                  state_d = WB;
               end
               default: state_d = TRAP;
            endcase
         end
         MEM: begin
            imm_sel   = imm_dec;
            alu_src_b = src_b_dec;
            mem_req   = 1'b1;
            addr_sel  = 1'b1;
            mem_we    = (opc == OP_ST);
            if (mem_ready) begin
               if (opc == OP_ST) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end
         end
         WB: begin
            imm_sel   = imm_dec;
            alu_src_b = src_b_dec;
            reg_we    = 1'b1;
            retire    = 1'b1;
            if (opc == OP_LD)                          wb_sel = 2'd1;
            else if (opc == OP_JAL || opc == OP_JALR)  wb_sel = 2'd2;
            state_d   = FETCH;
         end
         TRAP: trap = 1'b1;
         default: state_d = FETCH;
      endcase

      // Reset silences every output so a stale mem_ready cannot be consumed.
      if (rst) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         addr_sel  = 1'b0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         pc_sel    = 2'd0;
         imm_sel   = IMM_NONE;
         alu_src_b = 1'b0;
         reg_we    = 1'b0;
         wb_sel    = 2'd0;
         retire    = 1'b0;
         trap      = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors compared against
// hand-derived expectations for each instruction class, trap and reset.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic        mem_ready;
   logic        br_taken;
   logic        mem_req, mem_we, addr_sel, ir_we, pc_we;
   logic [1:0]  pc_sel;
   logic [2:0]  imm_sel;
   logic        alu_src_b, reg_we;
   logic [1:0]  wb_sel;
   logic        retire, trap;

   int total = 0;
   int bad   = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src_b(alu_src_b),
      .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .trap(trap)
   );

   always #5 clk = ~clk;

   logic [15:0] obs;
   assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, imm_sel,
                 alu_src_b, reg_we, wb_sel, retire, trap};

   // Field order: mem_req mem_we addr_sel ir_we pc_we pc_sel imm_sel alu_src_b reg_we wb_sel retire trap
   function automatic logic [15:0] ev(input int mrq, input int mwe, input int asl,
                                      input int irw, input int pcw, input int pcs,
                                      input int imm, input int asb, input int rwe,
                                      input int wbs, input int ret, input int trp);
      ev = {1'(mrq), 1'(mwe), 1'(asl), 1'(irw), 1'(pcw), 2'(pcs), 3'(imm),
            1'(asb), 1'(rwe), 2'(wbs), 1'(ret), 1'(trp)};
   endfunction

   task automatic test_reset();
      logic [15:0] e_zero, e_fw;
      e_zero = ev(0,0,0,0,0,0,7,0,0,0,0,0);
      e_fw   = ev(1,0,0,0,0,0,7,0,0,0,0,0);
      rst = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== e_zero) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, e_zero); end
      @(posedge clk); #1;
      rst = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== e_fw) begin bad++; $display("FAIL reset_first_req got=%h exp=%h", obs, e_fw); end
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      int          rdy[4] = '{1,1,1,1};
      logic [15:0] ex[4];
      ex[0] = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[1] = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[2] = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[3] = ev(0,0,0,0,0,0,0,1,1,0,1,0);
      inst = 32'h00500093;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'(rdy[i]);
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL addi cyc%0d got=%h exp=%h", i, obs, ex[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_add();
      logic [15:0] ex[4];
      ex[0] = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[1] = ev(0,0,0,0,0,0,7,0,0,0,0,0);
      ex[2] = ev(0,0,0,0,0,0,7,0,0,0,0,0);
      ex[3] = ev(0,0,0,0,0,0,7,0,1,0,1,0);
      inst = 32'h002081B3;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL add cyc%0d got=%h exp=%h", i, obs, ex[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_wait();
      int          rdy[9] = '{0,0,1,0,0,0,0,1,0};
      logic [15:0] ex[9];
      ex[0] = ev(1,0,0,0,0,0,7,0,0,0,0,0);
      ex[1] = ev(1,0,0,0,0,0,7,0,0,0,0,0);
      ex[2] = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[3] = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[4] = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[5] = ev(1,0,1,0,0,0,0,1,0,0,0,0);
      ex[6] = ev(1,0,1,0,0,0,0,1,0,0,0,0);
      ex[7] = ev(1,0,1,0,0,0,0,1,0,0,0,0);
      ex[8] = ev(0,0,0,0,0,0,0,1,1,1,1,0);
      inst = 32'h0000A103;
      for (int i = 0; i < 9; i++) begin
         mem_ready = 1'(rdy[i]);
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL lw cyc%0d got=%h exp=%h", i, obs, ex[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw();
      logic [15:0] ex[4];
      ex[0] = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[1] = ev(0,0,0,0,0,0,1,1,0,0,0,0);
      ex[2] = ev(0,0,0,0,0,0,1,1,0,0,0,0);
      ex[3] = ev(1,1,1,0,0,0,1,1,0,0,1,0);
      inst = 32'h0020A023;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL sw cyc%0d got=%h exp=%h", i, obs, ex[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_beq(input logic taken);
      logic [15:0] ex[3];
      ex[0] = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[1] = ev(0,0,0,0,0,0,2,0,0,0,0,0);
      ex[2] = ev(0,0,0,0,int'(taken),1,2,0,0,0,1,0);
      inst = 32'h00000463;
      mem_ready = 1'b1;
      br_taken = taken;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL beq%0d cyc%0d got=%h exp=%h", taken, i, obs, ex[i]); end
         @(posedge clk); #1;
      end
      br_taken = 1'b0;
   endtask

   task automatic test_jal_jalr(input logic is_jalr);
      logic [15:0] ex[4];
      int          imm;
      imm = is_jalr ? 0 : 3;
      ex[0] = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[1] = ev(0,0,0,0,0,0,imm,1,0,0,0,0);
      ex[2] = ev(0,0,0,0,1,is_jalr ? 2 : 1,imm,1,0,0,0,0);
      ex[3] = ev(0,0,0,0,0,0,imm,1,1,2,1,0);
      inst = is_jalr ? 32'h000080E7 : 32'h0000006F;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL jal%0d cyc%0d got=%h exp=%h", is_jalr, i, obs, ex[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_trap();
      int          rs[8] = '{0,0,0,0,0,0,1,0};
      logic [15:0] ex[8];
      ex[0] = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[1] = ev(0,0,0,0,0,0,7,0,0,0,0,0);
      ex[2] = ev(0,0,0,0,0,0,7,0,0,0,0,1);
      ex[3] = ev(0,0,0,0,0,0,7,0,0,0,0,1);
      ex[4] = ev(0,0,0,0,0,0,7,0,0,0,0,1);
      ex[5] = ev(0,0,0,0,0,0,7,0,0,0,0,1);
      ex[6] = ev(0,0,0,0,0,0,7,0,0,0,0,0);
      ex[7] = ev(1,0,0,0,0,0,7,0,0,0,0,0);
      inst = 32'h0000007F;
      for (int i = 0; i < 8; i++) begin
         mem_ready = (i < 6);
         rst = 1'(rs[i]);
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL trap cyc%0d got=%h exp=%h", i, obs, ex[i]); end
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_mem();
      int          rdy[11] = '{1,0,0,0,0,1,0,1,0,1,0};
      int          rs[11]  = '{0,0,0,0,0,1,0,0,0,0,0};
      logic [15:0] ex[11];
      ex[0]  = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[1]  = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[2]  = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[3]  = ev(1,0,1,0,0,0,0,1,0,0,0,0);
      ex[4]  = ev(1,0,1,0,0,0,0,1,0,0,0,0);
      ex[5]  = ev(0,0,0,0,0,0,7,0,0,0,0,0);
      ex[6]  = ev(1,0,0,0,0,0,7,0,0,0,0,0);
      ex[7]  = ev(1,0,0,1,1,0,7,0,0,0,0,0);
      ex[8]  = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[9]  = ev(0,0,0,0,0,0,0,1,0,0,0,0);
      ex[10] = ev(1,0,1,0,0,0,0,1,0,0,0,0);
      inst = 32'h0000A103;
      for (int i = 0; i < 11; i++) begin
         mem_ready = 1'(rdy[i]);
         rst = 1'(rs[i]);
         @(negedge clk);
         total++;
         if (obs !== ex[i]) begin bad++; $display("FAIL rst_mem cyc%0d got=%h exp=%h", i, obs, ex[i]); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1; inst = 32'h0; mem_ready = 1'b0; br_taken = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_addi();
      test_add();
      test_lw_wait();
      test_sw();
      test_beq(1'b1);
      test_beq(1'b0);
      test_jal_jalr(1'b1);
      test_jal_jalr(1'b0);
      test_trap();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
